// File: rtl/ro_puf_challenge_sequencer.sv
// Sequences one RO PUF response extraction: walks RESP_BITS consecutive challenges
// through the scrambler, times each RO counting window and resolves one bit per challenge.
module ro_puf_challenge_sequencer #(
  parameter int unsigned RESP_BITS   = 16,
  parameter int unsigned SCR_LAT     = 2,
  parameter int unsigned MEAS_CYCLES = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           base_challenge,
  output logic [7:0]           scr_challenge,
  input  logic [7:0]           scr_out,
  output logic [7:0]           ro_sel,
  output logic                 cnt_clr,
  output logic                 ro_en,
  input  logic [CNT_W-1:0]     cnt_a,
  input  logic [CNT_W-1:0]     cnt_b,
  output logic                 busy,
  output logic [RESP_BITS-1:0] response,
  output logic                 resp_valid,
  output logic                 unstable
);

  localparam int unsigned IDX_W   = $clog2(RESP_BITS);
  localparam int unsigned TMR_MAX = (MEAS_CYCLES > SCR_LAT) ? MEAS_CYCLES : SCR_LAT;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_MEASURE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             base_q, base_d;
  logic [7:0]             scr_d;
  logic [7:0]             ro_sel_d;
  logic [RESP_BITS-1:0]   resp_d;
  logic                   unstable_d;
  logic                   cnt_clr_d;
  logic                   ro_en_d;
  logic                   busy_d;
  logic                   resp_valid_d;

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tmr_q         <= '0;
      idx_q         <= '0;
      base_q        <= '0;
      scr_challenge <= '0;
      ro_sel        <= '0;
      response      <= '0;
      unstable      <= 1'b0;
      cnt_clr       <= 1'b0;
      ro_en         <= 1'b0;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      idx_q         <= idx_d;
      base_q        <= base_d;
      scr_challenge <= scr_d;
      ro_sel        <= ro_sel_d;
      response      <= resp_d;
      unstable      <= unstable_d;
      cnt_clr       <= cnt_clr_d;
      ro_en         <= ro_en_d;
      busy          <= busy_d;
      resp_valid    <= resp_valid_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    base_d     = base_q;
    scr_d      = scr_challenge;
    ro_sel_d   = ro_sel;
    resp_d     = response;
    unstable_d = unstable;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          base_d     = base_challenge;
          idx_d      = '0;
          resp_d     = '0;
          unstable_d = 1'b0;
          scr_d      = base_challenge;
          tmr_d      = TMR_W'(SCR_LAT - 1);
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (tmr_q == '0) begin
          state_d = S_CLEAR;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_CLEAR: begin
        ro_sel_d = scr_out;
        tmr_d    = TMR_W'(MEAS_CYCLES - 1);
        state_d  = S_MEASURE;
      end
      S_MEASURE: begin
        if (tmr_q == '0) begin
          state_d = S_SETTLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_SETTLE: begin
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        resp_d[idx_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b) begin
          unstable_d = 1'b1;
        end
        if (idx_q == IDX_W'(RESP_BITS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          scr_d   = base_q + 8'(idx_q) + 8'd1;
          tmr_d   = TMR_W'(SCR_LAT - 1);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort discards any partial result so nothing half-measured leaks out.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      resp_d     = '0;
      unstable_d = 1'b0;
    end

    cnt_clr_d    = (state_d == S_CLEAR);
    ro_en_d      = (state_d == S_MEASURE);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_ro_puf_challenge_sequencer.sv
// Bench for ro_puf_challenge_sequencer: scrambler and RO counter models drive the DUT,
// a challenge-level reference model predicts the response.
module tb_ro_puf_challenge_sequencer;

  localparam int RB = 4;
  localparam int SL = 2;
  localparam int MC = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    base_challenge = '0;
  logic [7:0]    scr_challenge;
  logic [7:0]    scr_out;
  logic [7:0]    ro_sel;
  logic          cnt_clr;
  logic          ro_en;
  logic [CW-1:0] cnt_a = '0;
  logic [CW-1:0] cnt_b = '0;
  logic          busy;
  logic [RB-1:0] response;
  logic          resp_valid;
  logic          unstable;

  int errors = 0;
  int checks = 0;

  // mode per scrambled challenge: 0 -> a<b, 1 -> a>b, 2 -> tie
  int mode_tbl [256];

  ro_puf_challenge_sequencer #(
    .RESP_BITS(RB), .SCR_LAT(SL), .MEAS_CYCLES(MC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_challenge(base_challenge), .scr_challenge(scr_challenge), .scr_out(scr_out),
    .ro_sel(ro_sel), .cnt_clr(cnt_clr), .ro_en(ro_en), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .busy(busy), .response(response), .resp_valid(resp_valid), .unstable(unstable)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] scr_f(input logic [7:0] x);
    return {x[4:0], x[7:5]} ^ 8'h5A;
  endfunction

  // Scrambler model with SL cycles of latency.
  logic [7:0] pipe [SL];
  always @(posedge clk) begin
    pipe[0] <= scr_f(scr_challenge);
    for (int i = 1; i < SL; i++) pipe[i] <= pipe[i-1];
  end
  assign scr_out = pipe[SL-1];

  // RO counter model: common random rate, +1 for the winning oscillator.
  logic [CW-1:0] inc = CW'(1);
  always @(negedge clk) inc <= CW'($urandom_range(1, 5));
  always @(posedge clk) begin
    if (cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (ro_en) begin
      cnt_a <= cnt_a + inc + ((mode_tbl[ro_sel] == 1) ? CW'(1) : CW'(0));
      cnt_b <= cnt_b + inc + ((mode_tbl[ro_sel] == 0) ? CW'(1) : CW'(0));
    end
  end

  // Event recorder, read by the scenario tasks.
  int         cyc = 0;
  logic       prev_en = 1'b0;
  logic       prev_clr = 1'b0;
  logic [7:0] prev_sel = '0;
  int         run = 0;
  int         overlap_cnt = 0;
  int         noclr_cnt = 0;
  int         selchg_cnt = 0;
  int         runs_q [$];
  logic [7:0] chal_q [$];
  logic [7:0] sel_q [$];
  int         rv_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ro_en && cnt_clr) overlap_cnt <= overlap_cnt + 1;
    if (ro_en && !prev_en) begin
      if (!prev_clr) noclr_cnt <= noclr_cnt + 1;
      chal_q.push_back(scr_challenge);
      sel_q.push_back(ro_sel);
    end
    if (ro_en && prev_en && (ro_sel != prev_sel)) selchg_cnt <= selchg_cnt + 1;
    if (ro_en) run <= run + 1;
    else if (prev_en) begin
      runs_q.push_back(run);
      run <= 0;
    end
    if (resp_valid) rv_cyc_q.push_back(cyc);
    prev_en  <= ro_en;
    prev_clr <= cnt_clr;
    prev_sel <= ro_sel;
  end

  // Reference model: bit i wins iff the RO pair chosen by challenge base+i favours A.
  function automatic logic [RB-1:0] model_resp(input logic [7:0] b);
    logic [RB-1:0] r;
    logic [7:0]    c;
    r = '0;
    for (int i = 0; i < RB; i++) begin
      c = b + 8'(i);
      r[i] = (mode_tbl[scr_f(c)] == 1);
    end
    return r;
  endfunction

  function automatic logic model_unst(input logic [7:0] b);
    logic       u;
    logic [7:0] c;
    u = 1'b0;
    for (int i = 0; i < RB; i++) begin
      c = b + 8'(i);
      if (mode_tbl[scr_f(c)] == 2) u = 1'b1;
    end
    return u;
  endfunction

  task automatic fill_modes(input int max_mode);
    for (int i = 0; i < 256; i++) begin
      if (max_mode >= 2) mode_tbl[i] = ($urandom_range(0, 4) == 4) ? 2 : int'($urandom_range(0, 1));
      else mode_tbl[i] = int'($urandom_range(0, 1));
    end
  endtask

  task automatic kick(input logic [7:0] b, output int t0);
    base_challenge = b;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (scr_challenge !== 8'h00) begin errors++; $display("FAIL reset_scr: got %h want 00", scr_challenge); end
    checks++; if (ro_sel !== 8'h00) begin errors++; $display("FAIL reset_ro_sel: got %h want 00", ro_sel); end
    checks++; if (response !== '0) begin errors++; $display("FAIL reset_response: got %h want 0", response); end
    checks++; if ({cnt_clr, ro_en, busy, resp_valid, unstable} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {cnt_clr, ro_en, busy, resp_valid, unstable});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_nominal;
    int t0, s_ch, s_run, s_rv, ov, nc, sc;
    for (int c = 0; c < 256; c++) mode_tbl[scr_f(8'(c))] = (c % 2 == 0) ? 1 : 0;
    s_ch = chal_q.size(); s_run = runs_q.size(); s_rv = rv_cyc_q.size();
    ov = overlap_cnt; nc = noclr_cnt; sc = selchg_cnt;
    kick(8'h10, t0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_rise: got %b want 1", busy); end
    checks++; if (scr_challenge !== 8'h10) begin errors++; $display("FAIL nom_first_chal: got %h want 10", scr_challenge); end
    until_cyc(t0 + 52);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL nom_rv_early: got %b want 0", resp_valid); end
    until_cyc(t0 + 53);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL nom_rv_53: got %b want 1", resp_valid); end
    checks++; if (response !== 4'b0101) begin errors++; $display("FAIL nom_response: got %b want 0101", response); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL nom_unstable: got %b want 0", unstable); end
    @(negedge clk);
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL nom_after_done: got %b want 00", {resp_valid, busy}); end
    checks++;
    if (chal_q.size() - s_ch != RB) begin
      errors++; $display("FAIL nom_chal_count: got %0d want %0d", chal_q.size() - s_ch, RB);
    end else begin
      for (int i = 0; i < RB; i++) begin
        checks++; if (chal_q[s_ch+i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL nom_chal%0d: got %h want %h", i, chal_q[s_ch+i], 8'(8'h10 + i)); end
        checks++; if (sel_q[s_ch+i] !== scr_f(8'(8'h10 + i))) begin errors++; $display("FAIL nom_sel%0d: got %h want %h", i, sel_q[s_ch+i], scr_f(8'(8'h10 + i))); end
      end
    end
    checks++; if (runs_q.size() - s_run != RB) begin errors++; $display("FAIL nom_run_count: got %0d want %0d", runs_q.size() - s_run, RB); end
    for (int i = s_run; i < runs_q.size(); i++) begin
      checks++; if (runs_q[i] != MC) begin errors++; $display("FAIL nom_run_len: got %0d want %0d", runs_q[i], MC); end
    end
    checks++; if (rv_cyc_q.size() - s_rv != 1) begin errors++; $display("FAIL nom_rv_count: got %0d want 1", rv_cyc_q.size() - s_rv); end
    checks++; if (overlap_cnt - ov != 0) begin errors++; $display("FAIL nom_overlap: got %0d want 0", overlap_cnt - ov); end
    checks++; if (noclr_cnt - nc != 0) begin errors++; $display("FAIL nom_no_clear: got %0d want 0", noclr_cnt - nc); end
    checks++; if (selchg_cnt - sc != 0) begin errors++; $display("FAIL nom_sel_moves: got %0d want 0", selchg_cnt - sc); end
  endtask

  task automatic test_wrap_tie;
    int t0, s_ch;
    logic [7:0] wexp [4];
    wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    fill_modes(1);
    mode_tbl[scr_f(8'hFF)] = 2;
    s_ch = chal_q.size();
    kick(8'hFE, t0);
    until_cyc(t0 + 53);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wrap_rv: got %b want 1", resp_valid); end
    checks++; if (response !== model_resp(8'hFE)) begin errors++; $display("FAIL wrap_response: got %b want %b", response, model_resp(8'hFE)); end
    checks++; if (response[1] !== 1'b0) begin errors++; $display("FAIL tie_bit1: got %b want 0", response[1]); end
    checks++; if (unstable !== 1'b1) begin errors++; $display("FAIL tie_unstable: got %b want 1", unstable); end
    checks++;
    if (chal_q.size() - s_ch != RB) begin
      errors++; $display("FAIL wrap_chal_count: got %0d want %0d", chal_q.size() - s_ch, RB);
    end else begin
      for (int i = 0; i < RB; i++) begin
        checks++; if (chal_q[s_ch+i] !== wexp[i]) begin errors++; $display("FAIL wrap_chal%0d: got %h want %h", i, chal_q[s_ch+i], wexp[i]); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int t0, s_rv;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) mode_tbl[i] = 1;
    b = 8'($urandom);
    s_rv = rv_cyc_q.size();
    kick(b, t0);
    until_cyc(t0 + 32);
    checks++; if (ro_en !== 1'b1) begin errors++; $display("FAIL abort_in_measure: got %b want 1", ro_en); end
    checks++; if (response !== (model_resp(b) & 4'b0011)) begin errors++; $display("FAIL abort_partial: got %b want %b", response, model_resp(b) & 4'b0011); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if ({ro_en, cnt_clr, busy} !== 3'b000) begin errors++; $display("FAIL abort_ctrl: got %b want 000", {ro_en, cnt_clr, busy}); end
    checks++; if ({response, unstable} !== '0) begin errors++; $display("FAIL abort_clear: got %h want 0", {response, unstable}); end
    until_cyc(t0 + 70);
    checks++; if (rv_cyc_q.size() != s_rv) begin errors++; $display("FAIL abort_no_rv: got %0d want 0", rv_cyc_q.size() - s_rv); end
    fill_modes(2);
    b = 8'($urandom);
    kick(b, t0);
    until_cyc(t0 + 53);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL post_abort_rv: got %b want 1", resp_valid); end
    checks++; if ({response, unstable} !== {model_resp(b), model_unst(b)}) begin
      errors++; $display("FAIL post_abort_resp: got %b want %b", {response, unstable}, {model_resp(b), model_unst(b)});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int t0;
    logic [7:0] b;
    fill_modes(1);
    b = 8'($urandom);
    kick(b, t0);
    until_cyc(t0 + 32);
    checks++; if (ro_en !== 1'b1) begin errors++; $display("FAIL rstmid_in_measure: got %b want 1", ro_en); end
    rst = 1'b1;
    #1;
    checks++; if ({scr_challenge, ro_sel, response, cnt_clr, ro_en, busy, resp_valid, unstable} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got %h want 0", {scr_challenge, ro_sel, response, cnt_clr, ro_en, busy, resp_valid, unstable});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_modes(2);
    b = 8'($urandom);
    kick(b, t0);
    until_cyc(t0 + 53);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_rerun_rv: got %b want 1", resp_valid); end
    checks++; if ({response, unstable} !== {model_resp(b), model_unst(b)}) begin
      errors++; $display("FAIL rstmid_rerun_resp: got %b want %b", {response, unstable}, {model_resp(b), model_unst(b)});
    end
    @(negedge clk);
  endtask

  task automatic test_protocol;
    int t0, s_run, s_rv, ov, nc;
    logic [7:0] b;
    fill_modes(1);
    b = 8'($urandom);
    s_run = runs_q.size(); s_rv = rv_cyc_q.size(); ov = overlap_cnt; nc = noclr_cnt;
    kick(b, t0);
    until_cyc(t0 + 5);
    base_challenge = ~b; start = 1'b1;
    @(negedge clk); start = 1'b0;
    until_cyc(t0 + 30);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    until_cyc(t0 + 53);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL proto_rv: got %b want 1", resp_valid); end
    checks++; if (response !== model_resp(b)) begin errors++; $display("FAIL proto_response: got %b want %b", response, model_resp(b)); end
    until_cyc(t0 + 60);
    checks++; if (rv_cyc_q.size() - s_rv != 1) begin errors++; $display("FAIL proto_rv_count: got %0d want 1", rv_cyc_q.size() - s_rv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL proto_idle: got %b want 0", busy); end
    checks++; if (runs_q.size() - s_run != RB) begin errors++; $display("FAIL proto_run_count: got %0d want %0d", runs_q.size() - s_run, RB); end
    for (int i = s_run; i < runs_q.size(); i++) begin
      checks++; if (runs_q[i] != MC) begin errors++; $display("FAIL proto_run_len: got %0d want %0d", runs_q[i], MC); end
    end
    checks++; if ((overlap_cnt - ov) + (noclr_cnt - nc) != 0) begin
      errors++; $display("FAIL proto_clr_en: got %0d want 0", (overlap_cnt - ov) + (noclr_cnt - nc));
    end
    s_run = runs_q.size();
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b want 0", busy); end
    repeat (SL + 4) @(negedge clk);
    checks++; if ({busy, ro_en, cnt_clr} !== 3'b000 || runs_q.size() != s_run) begin
      errors++; $display("FAIL start_abort_idle: got %b want 000", {busy, ro_en, cnt_clr});
    end
  endtask

  task automatic test_back_to_back;
    int t0;
    logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      fill_modes(2);
      b = 8'($urandom);
      kick(b, t0);
      until_cyc(t0 + 53);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rv%0d: got %b want 1", it, resp_valid); end
      checks++; if (response !== model_resp(b)) begin errors++; $display("FAIL b2b_resp%0d: got %b want %b", it, response, model_resp(b)); end
      checks++; if (unstable !== model_unst(b)) begin errors++; $display("FAIL b2b_unst%0d: got %b want %b", it, unstable, model_unst(b)); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d: got %b want 0", it, busy); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mode_tbl[i] = 0;
    test_reset();
    test_nominal();
    test_wrap_tie();
    test_abort();
    test_reset_mid();
    test_protocol();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
